// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory port arbiter.
// Optional statistics counters are enabled with the DMEM_ARB_STATS_EN macro.
package dmem_arb_pkg;

  // Arbitration mode, encoded explicitly so the encoding is stable across tools
  typedef enum logic [1:0] {
    ARB_CPU_PRI   = 2'd0,
    ARB_HOST_PRI  = 2'd1,
    ARB_HOST_LOCK = 2'd2
  } arb_state_e;

  // Owner tag carried with each read through the return pipeline
  localparam logic OWNER_CPU  = 1'b0;
  localparam logic OWNER_HOST = 1'b1;

  // Width of the optional statistics counters
  localparam int STAT_W = 32;

  // Increment that sticks at all-ones instead of wrapping
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/dmem_arb_rd_tag_pipe.sv
// Read-return tag pipeline: carries (valid, owner) for each issued SRAM read
// for RD_LAT cycles so the returning data can be steered to its requester.
module dmem_arb_rd_tag_pipe
  import dmem_arb_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic clk,
  input  logic arst_n,
  input  logic in_valid,
  input  logic in_owner,
  output logic cpu_rvalid,
  output logic host_rvalid
);

  logic [RD_LAT-1:0] vld_q;
  logic [RD_LAT-1:0] own_q;

  // Shift the tag one stage per cycle; reset drops every in-flight read
  // NOTE: state updates use <= so each stage samples its neighbour's old value.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      vld_q <= '0;
      own_q <= '0;
    end else begin
      vld_q[0] <= in_valid;
      own_q[0] <= in_owner;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        own_q[i] <= own_q[i-1];
      end
    end
  end

  assign cpu_rvalid  = vld_q[RD_LAT-1] & (own_q[RD_LAT-1] == OWNER_CPU);
  assign host_rvalid = vld_q[RD_LAT-1] & (own_q[RD_LAT-1] == OWNER_HOST);

endmodule

// File: rtl/dmem_port_arbiter.sv
// Arbiter sharing one single-port data SRAM between the CPU MEM stage and the
// host load/debug port. CPU has priority; a starvation counter and a host
// lock mode guarantee host progress. Define DMEM_ARB_STATS_EN to add
// saturating access/conflict/stall counters on extra output ports.
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W   = 64,
  parameter int DATA_W   = 64,
  parameter int MAX_WAIT = 8,
  parameter int RD_LAT   = 1
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              cpu_req,
  input  logic              cpu_wen,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_stall,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  input  logic              host_req,
  input  logic              host_wen,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  input  logic              host_lock,
  output logic              host_gnt,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_rvalid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wen,
  output logic              mem_ren,
  output logic [DATA_W-1:0] mem_wdata,
`ifdef DMEM_ARB_STATS_EN
  output logic [STAT_W-1:0] stat_cpu_acc,
  output logic [STAT_W-1:0] stat_host_acc,
  output logic [STAT_W-1:0] stat_conflict,
  output logic [STAT_W-1:0] stat_cpu_stall,
`endif
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [7:0] WAIT_MAX = 8'(MAX_WAIT);

  arb_state_e        state_q, state_d;
  logic [7:0]        wait_cnt_q, wait_cnt_d;

  logic              cmd_valid;
  logic              cmd_wen;
  logic              cmd_owner;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              cmd_owner_q;

  logic [DATA_W-1:0] cpu_rdata_q;
  logic [DATA_W-1:0] host_rdata_q;

  // Grant decode and next arbitration mode from current mode and requests
  // NOTE: every output of this block is given a default first so no path
  // through the case statement leaves a value unassigned (no latches).
  always_comb begin
    cpu_gnt  = 1'b0;
    host_gnt = 1'b0;
    state_d  = state_q;
    case (state_q)
      ARB_CPU_PRI: begin
        cpu_gnt  = cpu_req;
        host_gnt = host_req & ~cpu_req;
        if (host_gnt && host_lock) begin
          state_d = ARB_HOST_LOCK;
        end else if ((wait_cnt_q == WAIT_MAX) && !host_gnt) begin
          state_d = ARB_HOST_PRI;
        end
      end
      ARB_HOST_PRI: begin
        host_gnt = host_req;
        cpu_gnt  = cpu_req & ~host_req;
        // Any cycle with host_req set is a host accept in this mode
        if (host_req && host_lock) begin
          state_d = ARB_HOST_LOCK;
        end else begin
          state_d = ARB_CPU_PRI;
        end
      end
      ARB_HOST_LOCK: begin
        // The cycle that releases the lock still serves a pending host command
        host_gnt = host_req;
        if (!host_lock || !host_req) begin
          state_d = ARB_CPU_PRI;
        end
      end
      default: state_d = ARB_CPU_PRI;
    endcase
  end

  assign cpu_stall = cpu_req & ~cpu_gnt;

  // Starvation counter: counts host wait cycles, sticks at the threshold
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!host_req || host_gnt) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q != WAIT_MAX) begin
      wait_cnt_d = wait_cnt_q + 8'd1;
    end
  end

  // Arbitration mode and starvation counter registers
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q    <= ARB_CPU_PRI;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Select the winning command; at most one grant is ever active
  always_comb begin
    cmd_valid = cpu_gnt | host_gnt;
    cmd_owner = host_gnt ? OWNER_HOST : OWNER_CPU;
    cmd_wen   = host_gnt ? host_wen   : cpu_wen;
    cmd_addr  = host_gnt ? host_addr  : cpu_addr;
    cmd_wdata = host_gnt ? host_wdata : cpu_wdata;
  end

  // Command register: drives the SRAM port the cycle after acceptance, idle is all-zero
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      mem_addr    <= '0;
      mem_wen     <= 1'b0;
      mem_ren     <= 1'b0;
      mem_wdata   <= '0;
      cmd_owner_q <= OWNER_CPU;
    end else if (cmd_valid) begin
      mem_addr    <= cmd_addr;
      mem_wen     <= cmd_wen;
      mem_ren     <= ~cmd_wen;
      mem_wdata   <= cmd_wdata;
      cmd_owner_q <= cmd_owner;
    end else begin
      mem_addr    <= '0;
      mem_wen     <= 1'b0;
      mem_ren     <= 1'b0;
      mem_wdata   <= '0;
      cmd_owner_q <= OWNER_CPU;
    end
  end

  // Tags enter the return pipeline alongside the SRAM read strobe
  dmem_arb_rd_tag_pipe #(
    .RD_LAT (RD_LAT)
  ) u_rd_tag_pipe (
    .clk         (clk),
    .arst_n      (arst_n),
    .in_valid    (mem_ren),
    .in_owner    (cmd_owner_q),
    .cpu_rvalid  (cpu_rvalid),
    .host_rvalid (host_rvalid)
  );

  // Hold the last data delivered to each requester between its rvalid pulses
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      cpu_rdata_q  <= '0;
      host_rdata_q <= '0;
    end else begin
      if (cpu_rvalid)  cpu_rdata_q  <= mem_rdata;
      if (host_rvalid) host_rdata_q <= mem_rdata;
    end
  end

  // SRAM data is only valid in the rvalid cycle itself, so it is passed
  // straight through then and the held copy is shown otherwise.
  assign cpu_rdata  = cpu_rvalid  ? mem_rdata : cpu_rdata_q;
  assign host_rdata = host_rvalid ? mem_rdata : host_rdata_q;

`ifdef DMEM_ARB_STATS_EN
  // Saturating statistics counters
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      stat_cpu_acc   <= '0;
      stat_host_acc  <= '0;
      stat_conflict  <= '0;
      stat_cpu_stall <= '0;
    end else begin
      if (cpu_gnt)            stat_cpu_acc   <= sat_inc(stat_cpu_acc);
      if (host_gnt)           stat_host_acc  <= sat_inc(stat_host_acc);
      if (cpu_req && host_req) stat_conflict <= sat_inc(stat_conflict);
      if (cpu_stall)          stat_cpu_stall <= sat_inc(stat_cpu_stall);
    end
  end
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed testbench for dmem_port_arbiter (default parameters: MAX_WAIT = 8,
// RD_LAT = 1). A small behavioural SRAM answers reads one cycle after mem_ren.
module tb_dmem_port_arbiter;

  localparam int AW = 64;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          arst_n;
  logic          cpu_req, cpu_wen, cpu_gnt, cpu_stall, cpu_rvalid;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          host_req, host_wen, host_lock, host_gnt, host_rvalid;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata, host_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_wen, mem_ren;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
`ifdef DMEM_ARB_STATS_EN
  logic [31:0]   stat_cpu_acc, stat_host_acc, stat_conflict, stat_cpu_stall;
`endif

  int n_vec = 0;
  int n_err = 0;
  int host_gnt_cnt;

  always #5 clk = ~clk;

  dmem_port_arbiter dut (
    .clk        (clk),
    .arst_n     (arst_n),
    .cpu_req    (cpu_req),
    .cpu_wen    (cpu_wen),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_gnt    (cpu_gnt),
    .cpu_stall  (cpu_stall),
    .cpu_rdata  (cpu_rdata),
    .cpu_rvalid (cpu_rvalid),
    .host_req   (host_req),
    .host_wen   (host_wen),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_lock  (host_lock),
    .host_gnt   (host_gnt),
    .host_rdata (host_rdata),
    .host_rvalid(host_rvalid),
    .mem_addr   (mem_addr),
    .mem_wen    (mem_wen),
    .mem_ren    (mem_ren),
    .mem_wdata  (mem_wdata),
`ifdef DMEM_ARB_STATS_EN
    .stat_cpu_acc  (stat_cpu_acc),
    .stat_host_acc (stat_host_acc),
    .stat_conflict (stat_conflict),
    .stat_cpu_stall(stat_cpu_stall),
`endif
    .mem_rdata  (mem_rdata)
  );

  // Behavioural SRAM: 512 words, preloaded with an address-derived pattern
  logic [DW-1:0] sram [512];

  function automatic logic [DW-1:0] fill(input logic [AW-1:0] a);
    return 64'hC0DE_0000_0000_0000 ^ a;
  endfunction

  initial begin
    for (int i = 0; i < 512; i++) sram[i] = fill(64'(i) << 3);
  end

  always @(posedge clk) begin
    if (mem_wen) sram[mem_addr[11:3]] <= mem_wdata;
    if (mem_ren) mem_rdata <= sram[mem_addr[11:3]];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle();
    cpu_req = 0; cpu_wen = 0; cpu_addr = '0; cpu_wdata = '0;
    host_req = 0; host_wen = 0; host_addr = '0; host_wdata = '0; host_lock = 0;
  endtask

  // Advance to just after the next rising edge (inputs are driven here)
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    idle();
    arst_n = 1'b0;
    #12;
    // ---------------- reset state ----------------
    check("rst_ctrl", {cpu_gnt, host_gnt, cpu_stall, mem_ren, mem_wen, cpu_rvalid, host_rvalid}, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_cpu_rdata", cpu_rdata, 0);
    arst_n = 1'b1;
    next_cycle();

    // ---------------- single CPU read ----------------
    cpu_req = 1; cpu_wen = 0; cpu_addr = 64'h40;
    #4;
    check("t1_cpu_gnt", cpu_gnt, 1);
    check("t1_host_gnt", host_gnt, 0);
    check("t1_stall", cpu_stall, 0);
    next_cycle();
    cpu_req = 0;
    #4;
    check("t1_mem_ren", mem_ren, 1);
    check("t1_mem_wen", mem_wen, 0);
    check("t1_mem_addr", mem_addr, 64'h40);
    check("t1_rvalid_early", cpu_rvalid, 0);
    next_cycle();
    #4;
    check("t1_cpu_rvalid", cpu_rvalid, 1);
    check("t1_cpu_rdata", cpu_rdata, fill(64'h40));
    check("t1_host_rvalid", host_rvalid, 0);
    check("t1_mem_idle", mem_ren, 0);
    next_cycle();
    #4;
    check("t1_rvalid_pulse", cpu_rvalid, 0);
    check("t1_rdata_hold", cpu_rdata, fill(64'h40));
    next_cycle();

    // ---------------- starvation: host forced in at cycle 9 ----------------
    cpu_req = 1; cpu_wen = 0; cpu_addr = 64'h48;
    host_req = 1; host_wen = 0; host_addr = 64'h100;
    host_gnt_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      #4;
      if (host_gnt) host_gnt_cnt++;
      check($sformatf("t2_host_gnt[%0d]", i), host_gnt, 64'(i == 9));
      check($sformatf("t2_cpu_gnt[%0d]", i), cpu_gnt, 64'(i != 9));
      check($sformatf("t2_stall[%0d]", i), cpu_stall, 64'(i == 9));
      check($sformatf("t2_cpu_rvalid[%0d]", i), cpu_rvalid,
            64'((i >= 2 && i <= 10) || i >= 12));
      check($sformatf("t2_host_rvalid[%0d]", i), host_rvalid, 64'(i == 11));
      if (i == 11) check("t2_host_rdata", host_rdata, fill(64'h100));
      next_cycle();
      if (i == 9) host_req = 0;
    end
    check("t2_host_gnt_count", 64'(host_gnt_cnt), 1);
    idle();
    next_cycle();
    next_cycle();

    // ---------------- host lock burst of five writes ----------------
    cpu_req = 1; cpu_wen = 0; cpu_addr = 64'h50;
    host_req = 1; host_wen = 1; host_lock = 1;
    host_addr = 64'h200; host_wdata = 64'h1111_0000_0000_0000;
    for (int i = 0; i < 15; i++) begin
      #4;
      check($sformatf("t3_host_gnt[%0d]", i), host_gnt, 64'(i >= 9 && i <= 13));
      check($sformatf("t3_cpu_gnt[%0d]", i), cpu_gnt, 64'(!(i >= 9 && i <= 13)));
      check($sformatf("t3_stall[%0d]", i), cpu_stall, 64'(i >= 9 && i <= 13));
      if (i == 10) begin
        check("t3_first_wen", mem_wen, 1);
        check("t3_first_addr", mem_addr, 64'h200);
      end
      if (i == 14) begin
        check("t3_last_wen", mem_wen, 1);
        check("t3_last_addr", mem_addr, 64'h220);
        check("t3_last_wdata", mem_wdata, 64'h1111_0000_0000_0004);
      end
      next_cycle();
      if (i >= 9 && i <= 12) begin
        host_addr  = host_addr + 64'h8;
        host_wdata = host_wdata + 64'h1;
      end
      if (i == 12) host_lock = 0;
      if (i == 13) begin host_req = 0; host_wen = 0; end
    end
    idle();
    next_cycle();
    next_cycle();

    // ---------------- alternating writes, then one read each ----------------
    idle(); cpu_req = 1; cpu_wen = 1; cpu_addr = 64'h8; cpu_wdata = 64'hAAAA_0000_0000_0008;
    #4;
    check("t4_c0_cpu_gnt", {cpu_gnt, host_gnt}, 2'b10);
    next_cycle();
    idle(); host_req = 1; host_wen = 1; host_addr = 64'h10; host_wdata = 64'h5555_0000_0000_0010;
    #4;
    check("t4_c1_host_gnt", {cpu_gnt, host_gnt}, 2'b01);
    check("t4_c1_mem", {mem_wen, mem_ren}, 2'b10);
    check("t4_c1_addr", mem_addr, 64'h8);
    check("t4_c1_wdata", mem_wdata, 64'hAAAA_0000_0000_0008);
    next_cycle();
    idle(); cpu_req = 1; cpu_wen = 0; cpu_addr = 64'h8;
    #4;
    check("t4_c2_cpu_gnt", {cpu_gnt, host_gnt}, 2'b10);
    check("t4_c2_mem", {mem_wen, mem_ren}, 2'b10);
    check("t4_c2_addr", mem_addr, 64'h10);
    check("t4_c2_wdata", mem_wdata, 64'h5555_0000_0000_0010);
    next_cycle();
    idle(); host_req = 1; host_wen = 0; host_addr = 64'h10;
    #4;
    check("t4_c3_host_gnt", {cpu_gnt, host_gnt}, 2'b01);
    check("t4_c3_mem", {mem_wen, mem_ren}, 2'b01);
    check("t4_c3_addr", mem_addr, 64'h8);
    check("t4_c3_rvalid", {cpu_rvalid, host_rvalid}, 2'b00);
    next_cycle();
    idle();
    #4;
    check("t4_c4_mem", {mem_wen, mem_ren}, 2'b01);
    check("t4_c4_addr", mem_addr, 64'h10);
    check("t4_c4_rvalid", {cpu_rvalid, host_rvalid}, 2'b10);
    check("t4_c4_cpu_rdata", cpu_rdata, 64'hAAAA_0000_0000_0008);
    check("t4_c4_host_hold", host_rdata, fill(64'h100));
    next_cycle();
    #4;
    check("t4_c5_rvalid", {cpu_rvalid, host_rvalid}, 2'b01);
    check("t4_c5_host_rdata", host_rdata, 64'h5555_0000_0000_0010);
    check("t4_c5_cpu_hold", cpu_rdata, 64'hAAAA_0000_0000_0008);
    check("t4_c5_mem_idle", {mem_wen, mem_ren}, 2'b00);
    check("t4_c5_addr", mem_addr, 0);
    next_cycle();

    // ---------------- reset while reads are in flight ----------------
    cpu_req = 1; cpu_wen = 0; cpu_addr = 64'h40;
    host_req = 1; host_wen = 0; host_addr = 64'h100;
    for (int i = 0; i < 4; i++) next_cycle();
    idle();
    #2;
    arst_n = 1'b0;
    #1;
    check("t5_rst_ctrl", {cpu_gnt, host_gnt, cpu_stall, mem_ren, mem_wen, cpu_rvalid, host_rvalid}, 0);
    check("t5_rst_addr", mem_addr, 0);
    check("t5_rst_cpu_rdata", cpu_rdata, 0);
    check("t5_rst_host_rdata", host_rdata, 0);
    #2;
    arst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      next_cycle();
      #4;
      check($sformatf("t5_no_rvalid[%0d]", i), {cpu_rvalid, host_rvalid}, 2'b00);
      check($sformatf("t5_cpu_rdata[%0d]", i), cpu_rdata, 0);
    end
    next_cycle();
    // Counter and mode must be back at their reset values: host waits 9 full cycles
    cpu_req = 1; cpu_wen = 0; cpu_addr = 64'h40;
    host_req = 1; host_wen = 0; host_addr = 64'h100;
    for (int i = 0; i < 10; i++) begin
      #4;
      check($sformatf("t5_host_gnt[%0d]", i), host_gnt, 64'(i == 9));
      check($sformatf("t5_cpu_gnt[%0d]", i), cpu_gnt, 64'(i != 9));
      next_cycle();
      if (i == 9) host_req = 0;
    end
    idle();
`ifdef DMEM_ARB_STATS_EN
    #4;
    check("t6_stat_conflict", stat_conflict, 10);
    check("t6_stat_acc_sum", 64'(stat_cpu_acc) + 64'(stat_host_acc), 10);
    check("t6_stat_cpu_stall", stat_cpu_stall, 1);
`endif
    next_cycle();
    next_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
